// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver and scan-code set 2 decoder.
// Turns make codes into key_code/en_codigo strobes and tracks the time-setting mode and field selection.
module ps2_key_decoder #(
   parameter int N          = 8,
   parameter int P          = 2,
   parameter int MAX_POS    = 2,
   parameter int FILTER_LEN = 4,
   parameter int TIMEOUT    = 5000
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ps2_clk,
   input  logic         ps2_data,
   output logic [N-1:0] key_code,
   output logic         en_codigo,
   output logic         f1,
   output logic         f3,
   output logic [P-1:0] posicion,
   output logic         frame_err
);

   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PARITY,
      STOP
   } rxState_e;

   logic [1:0]    clkSync_q;
   logic [1:0]    dataSync_q;
   logic          filtClk_q;
   logic [3:0]    filtCnt_q;
   logic          fallEdge;
   logic          dataBit;

   rxState_e      state_q, state_d;
   logic [2:0]    bitCnt_q, bitCnt_d;
   logic [7:0]    shift_q, shift_d;
   logic          parity_q, parity_d;
   logic [TW-1:0] toCnt_q, toCnt_d;
   logic          rxValid_q, rxValid_d;
   logic [7:0]    rxByte_q, rxByte_d;
   logic          err_q, err_d;

   logic [N-1:0]  key_q, key_d;
   logic          en_q, en_d;
   logic          f1_q, f1_d;
   logic          f3_q, f3_d;
   logic [P-1:0]  pos_q, pos_d;
   logic          break_q, break_d;
   logic          extend_q, extend_d;

   // The filtered clock flips only once the synchronized pin has disagreed with it for FILTER_LEN samples in a row
   always_ff @(posedge clk) begin
      if (rst) begin
         clkSync_q  <= 2'b11;
         dataSync_q <= 2'b11;
         filtClk_q  <= 1'b1;
         filtCnt_q  <= '0;
      end else begin
         clkSync_q  <= {clkSync_q[0], ps2_clk};
         dataSync_q <= {dataSync_q[0], ps2_data};
         if (clkSync_q[1] == filtClk_q) begin
            filtCnt_q <= '0;
         end else if (filtCnt_q == 4'(FILTER_LEN - 1)) begin
            filtClk_q <= clkSync_q[1];
            filtCnt_q <= '0;
         end else begin
            filtCnt_q <= filtCnt_q + 4'd1;
         end
      end
   end

   assign fallEdge = filtClk_q & ~clkSync_q[1] & (filtCnt_q == 4'(FILTER_LEN - 1));
   assign dataBit  = dataSync_q[1];

   always_comb begin
      state_d   = state_q;
      bitCnt_d  = bitCnt_q;
      shift_d   = shift_q;
      parity_d  = parity_q;
      rxValid_d = 1'b0;
      rxByte_d  = rxByte_q;
      err_d     = 1'b0;
      toCnt_d   = (state_q == IDLE || fallEdge) ? '0 : toCnt_q + TW'(1);

      case (state_q)
         IDLE: begin
            if (fallEdge && !dataBit) begin
               state_d  = DATA;
               bitCnt_d = '0;
            end
         end
         DATA: begin
            if (fallEdge) begin
               shift_d  = {dataBit, shift_q[7:1]};
               bitCnt_d = bitCnt_q + 3'd1;
               if (bitCnt_q == 3'd7) state_d = PARITY;
            end
         end
         PARITY: begin
            if (fallEdge) begin
               parity_d = dataBit;
               state_d  = STOP;
            end
         end
         STOP: begin
            if (fallEdge) begin
               state_d = IDLE;
               if (dataBit && (^{shift_q, parity_q})) begin
                  rxValid_d = 1'b1;
                  rxByte_d  = shift_q;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // A stalled partial frame is abandoned so the next start bit is recognised cleanly
      if (state_q != IDLE && !fallEdge && toCnt_q == TW'(TIMEOUT - 1)) begin
         state_d   = IDLE;
         err_d     = 1'b1;
         rxValid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         bitCnt_q  <= '0;
         shift_q   <= '0;
         parity_q  <= 1'b0;
         toCnt_q   <= '0;
         rxValid_q <= 1'b0;
         rxByte_q  <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         bitCnt_q  <= bitCnt_d;
         shift_q   <= shift_d;
         parity_q  <= parity_d;
         toCnt_q   <= toCnt_d;
         rxValid_q <= rxValid_d;
         rxByte_q  <= rxByte_d;
         err_q     <= err_d;
      end
   end

   // Prefix bytes only set flags; a break-prefixed byte is swallowed so key releases never strobe
   always_comb begin
      key_d    = key_q;
      en_d     = 1'b0;
      f1_d     = f1_q;
      f3_d     = f3_q;
      pos_d    = pos_q;
      break_d  = break_q;
      extend_d = extend_q;

      if (rxValid_q) begin
         if (rxByte_q == 8'hE0) begin
            extend_d = 1'b1;
         end else if (rxByte_q == 8'hF0) begin
            break_d = 1'b1;
         end else if (break_q) begin
            break_d  = 1'b0;
            extend_d = 1'b0;
         end else begin
            key_d    = N'(rxByte_q);
            en_d     = 1'b1;
            extend_d = 1'b0;
            case (rxByte_q)
               8'h05: begin
                  f1_d  = 1'b1;
                  f3_d  = 1'b0;
                  pos_d = '0;
               end
               8'h04: begin
                  f1_d  = 1'b0;
                  f3_d  = 1'b1;
                  pos_d = '0;
               end
               8'h76: begin
                  f1_d  = 1'b0;
                  f3_d  = 1'b0;
                  pos_d = '0;
               end
               8'h74: begin
                  if (f1_q || f3_q) pos_d = (pos_q == P'(MAX_POS)) ? '0 : pos_q + P'(1);
               end
               8'h6B: begin
                  if (f1_q || f3_q) pos_d = (pos_q == '0) ? P'(MAX_POS) : pos_q - P'(1);
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         key_q    <= '0;
         en_q     <= 1'b0;
         f1_q     <= 1'b0;
         f3_q     <= 1'b0;
         pos_q    <= '0;
         break_q  <= 1'b0;
         extend_q <= 1'b0;
      end else begin
         key_q    <= key_d;
         en_q     <= en_d;
         f1_q     <= f1_d;
         f3_q     <= f3_d;
         pos_q    <= pos_d;
         break_q  <= break_d;
         extend_q <= extend_d;
      end
   end

   assign key_code  = key_q;
   assign en_codigo = en_q;
   assign f1        = f1_q;
   assign f3        = f3_q;
   assign posicion  = pos_q;
   assign frame_err = err_q;

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Receives raw PS/2 keyboard frames and decodes scan-code set 2 bytes.
- Drives the key_code / en_codigo strobe, f1/f3 mode flags and posicion field selector consumed by the hour/minute/second counter blocks.
- Sits between the board PS/2 pins and the time-setting counters. It is the producer end of the key-command interface those counters receive.

Parameters:
N, 8, key_code width (one PS/2 byte)
P, 2, posicion width
MAX_POS, 2, highest posicion value (0=hour, 1=minute, 2=second)
FILTER_LEN, 4, consecutive identical ps2_clk samples required to accept a level change (range 2..15)
TIMEOUT, 5000, clk cycles without a filtered ps2_clk falling edge before a partial frame is abandoned

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
ps2_clk  input  1  raw PS/2 clock pin (asynchronous)
ps2_data  input  1  raw PS/2 data pin (asynchronous)
key_code  output  N  last accepted make code
en_codigo  output  1  one-clk pulse: key_code holds a new make code
f1  output  1  time-set mode flag
f3  output  1  alarm/timer-set mode flag
posicion  output  P  field currently selected for editing
frame_err  output  1  one-clk pulse on parity/stop error or timeout

Behaviour:
- Reset (rst=1 at posedge clk): all outputs are 0. Receiver state is IDLE; bit counter, shift register, break/extend flags and filter are cleared. The filtered ps2_clk level resets to 1.
- Input conditioning:
  - ps2_clk and ps2_data each pass through a 2-flop synchronizer.
  - The filtered clock changes level only after FILTER_LEN consecutive identical synchronized samples.
  - A falling edge is a filtered 1->0 transition. ps2_data is sampled on that same clk cycle.
- Receiver FSM:
  - IDLE: on falling edge with data=0 (start bit), go to DATA with bit count 0. A falling edge with data=1 is ignored.
  - DATA: shift in 8 bits LSB first, one per falling edge. After the 8th bit, go to PARITY.
  - PARITY: sample the parity bit and go to STOP.
  - STOP: sample the stop bit. The frame is valid if the stop bit is 1 and the 9 bits (data plus parity) contain an odd number of ones. If valid, the byte goes to the decoder. If invalid, frame_err pulses. Return to IDLE either way.
  - In any non-IDLE state, if no falling edge arrives for TIMEOUT consecutive cycles, return to IDLE, pulse frame_err, and discard the partial byte.
- Decoder: one cycle after the STOP-sampling edge. All decoder outputs update on the same clk edge.
  - Byte 0xE0: set the extend flag and drop the byte.
  - Byte 0xF0: set the break flag and drop the byte.
  - Any other byte with break=1: dropped. Clear break and extend. No pulse, no flag or position change.
  - Any other byte with break=0 (make code): key_code<=byte, en_codigo=1 for exactly one cycle, clear extend. Extended arrows (E0 75/72/74/6B) therefore match the keypad 8/2/6/4 codes.
- Mode and position actions on a make code:
  - 0x05 (F1): f1<=1, f3<=0, posicion<=0.
  - 0x04 (F3): f3<=1, f1<=0, posicion<=0.
  - 0x76 (Esc): f1<=0, f3<=0, posicion<=0.
  - 0x74 (right): only when f1|f3. posicion<=(posicion==MAX_POS)?0:posicion+1.
  - 0x6B (left): only when f1|f3. posicion<=(posicion==0)?MAX_POS:posicion-1.
  - Left/right with f1=f3=0: posicion unchanged. en_codigo still pulses.
- Typematic repeats of a held key are new make codes; each one pulses en_codigo.
- key_code holds its value between pulses. f1 and f3 are never both 1.
- rst asserted mid-frame aborts the frame with no en_codigo and no frame_err. The next byte is decoded only from a fresh start bit.

Test Plan:
- Byte 0x75 with correct odd parity (ps2 clock period 40 clk, FILTER_LEN=4) -> key_code=0x75, single-cycle en_codigo, frame_err=0.
- Sequence F0 75 -> no en_codigo for either byte; key_code keeps its previous value; break flag cleared afterwards (next 0x72 pulses).
- Byte 0x05 -> f1=1, f3=0, posicion=0. Then 0x74 three times -> posicion 1, 2, 0. Then 0x6B -> posicion 2. Then 0x76 -> f1=0, posicion=0.
- With f1=f3=0, byte 0x74 -> en_codigo pulses, posicion stays 0. Then 0x04 -> f3=1, f1=0. Then E0 74 -> posicion=1.
- Byte 0x72 with wrong parity -> frame_err pulse, no en_codigo. Separately, stop after 4 data bits for TIMEOUT+10 cycles -> frame_err pulse, FSM back in IDLE, next good 0x72 decoded correctly.
- Glitch on ps2_clk 2 clk wide mid-frame -> ignored, byte decoded correctly. Separately, rst pulsed after bit 5 -> all outputs 0, no pulses, next full frame decoded.
